ahb_master_mux_pipe: RTL

- Parametrised N-master AHB-Lite bus mux.
- Successor to the fixed 3-master address mux. Adds a split address-phase/data-phase ownership pipeline, so HWDATA follows the master that owned the previous address phase.
- Ownership changes only on HREADY-qualified cycle boundaries. Out-of-range selects are flagged.
- Sits between the arbiter (supplies mux_sel) and the decoder/slave-side bus.

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_onehot_mux.sv | 29 ++
 rtl/ahb_master_mux_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and helpers for the bus-side mux blocks.
package ahb_pkg;

    localparam int HTRANS_W = 2;
    localparam int HSIZE_W  = 3;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    localparam int DEFAULT_MASTER = 0;

    // Only NONSEQ and SEQ start a data phase; IDLE and BUSY do not.
    function automatic logic trans_active(input logic [HTRANS_W-1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_onehot_mux.sv
// Generic N:1 mux on a binary index; an index with no matching input yields zero.
module ahb_onehot_mux #(
    parameter int N     = 3,
    parameter int W     = 32,
    parameter int SEL_W = 2
) (
    input  logic [N*W-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]   dout
);

    logic [N-1:0] onehot;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (sel == SEL_W'(i));
        end
    end

    // AND-OR selection keeps the out-of-range case at zero without a priority chain.
    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            dout = dout | ({W{onehot[i]}} & din[i*W +: W]);
        end
    end

endmodule

// File: rtl/ahb_master_mux_pipe.sv
// N-master AHB-Lite bus mux with separate address-phase and data-phase ownership.
module ahb_master_mux_pipe
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 2
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
    input  logic [NUM_MASTERS-1:0]        m_hwrite,
    input  logic [NUM_MASTERS*2-1:0]      m_htrans,
    input  logic [NUM_MASTERS*3-1:0]      m_hsize,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
    input  logic [SEL_W-1:0]              mux_sel,
    input  logic                          hready,
    output logic [ADDR_W-1:0]             haddr,
    output logic                          hwrite,
    output logic [1:0]                    htrans,
    output logic [2:0]                    hsize,
    output logic [DATA_W-1:0]             hwdata,
    output logic [SEL_W-1:0]              hmaster,
    output logic [SEL_W-1:0]              hmaster_data,
    output logic                          data_active,
    output logic                          sel_err
);

    localparam int CTRL_W = ADDR_W + 1 + HTRANS_W + HSIZE_W;
    localparam logic [SEL_W:0]   MASTER_LIMIT  = (SEL_W+1)'(NUM_MASTERS);
    localparam logic [SEL_W-1:0] DEFAULT_OWNER = SEL_W'(DEFAULT_MASTER);

    logic [SEL_W-1:0]              addr_owner;
    logic [SEL_W-1:0]              data_owner;
    logic [NUM_MASTERS*CTRL_W-1:0] ctrl_bundle;
    logic [CTRL_W-1:0]             ctrl_sel;
    logic [ADDR_W-1:0]             sel_haddr;
    logic                          sel_hwrite;
    logic [HTRANS_W-1:0]           sel_htrans;
    logic [HSIZE_W-1:0]            sel_hsize;
    logic [DATA_W-1:0]             wdata_sel;
    logic                          sel_in_range;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_bundle
        assign ctrl_bundle[i*CTRL_W +: CTRL_W] = {m_haddr[i*ADDR_W +: ADDR_W],
                                                  m_hwrite[i],
                                                  m_htrans[i*HTRANS_W +: HTRANS_W],
                                                  m_hsize[i*HSIZE_W +: HSIZE_W]};
    end

    ahb_onehot_mux #(
        .N     (NUM_MASTERS),
        .W     (CTRL_W),
        .SEL_W (SEL_W)
    ) u_ctrl_mux (
        .din  (ctrl_bundle),
        .sel  (addr_owner),
        .dout (ctrl_sel)
    );

    ahb_onehot_mux #(
        .N     (NUM_MASTERS),
        .W     (DATA_W),
        .SEL_W (SEL_W)
    ) u_wdata_mux (
        .din  (m_hwdata),
        .sel  (data_owner),
        .dout (wdata_sel)
    );

    assign {sel_haddr, sel_hwrite, sel_htrans, sel_hsize} = ctrl_sel;
    assign sel_in_range = ({1'b0, mux_sel} < MASTER_LIMIT);

    // The slave side must see an idle bus while reset is held, whatever the masters drive.
    always_comb begin
        haddr  = '0;
        hwrite = 1'b0;
        htrans = HTRANS_IDLE;
        hsize  = '0;
        hwdata = '0;
        if (!hreset) begin
            haddr  = sel_haddr;
            hwrite = sel_hwrite;
            htrans = sel_htrans;
            hsize  = sel_hsize;
            if (data_active) begin
                hwdata = wdata_sel;
            end
        end
    end

    // Ownership only advances on HREADY, so a stalled transfer keeps both phases intact.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            addr_owner  <= DEFAULT_OWNER;
            data_owner  <= DEFAULT_OWNER;
            data_active <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            if (hready) begin
                data_owner  <= addr_owner;
                data_active <= trans_active(sel_htrans);
                if (sel_in_range) begin
                    addr_owner <= mux_sel;
                end else begin
                    addr_owner <= DEFAULT_OWNER;
                    sel_err    <= 1'b1;
                end
            end
        end
    end

    assign hmaster      = addr_owner;
    assign hmaster_data = data_owner;

endmodule
